uart_tx_frame_ctrl: RTL and testbench

Frame sequencer for the UART transmitter: accepts a parallel word, then steps through start, data, optional parity and stop phases at one phase per clock. It drives the output multiplexer's select, the serial data bit and the parity bit. It sits directly upstream of the TX output mux and runs on the baud-rate clock.

---
 rtl/uart_tx_pkg.sv | 20 ++
 rtl/uart_tx_parity_calc.sv | 14 +
 rtl/uart_tx_frame_ctrl.sv | 151 +++++++++++++++
 tb/tb_uart_tx_frame_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared encodings for the UART TX frame sequencer and the downstream output mux.
// UART_TX_PARITY_EN adds the PARITY state to the state encoding.
package uart_tx_pkg;

  localparam logic [1:0] MUX_START  = 2'b00;
  localparam logic [1:0] MUX_SERIAL = 2'b01;
  localparam logic [1:0] MUX_PARITY = 2'b10;
  localparam logic [1:0] MUX_STOP   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity of a payload word: XOR-reduce, inverted for odd parity.
module uart_tx_parity_calc #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  odd_i,
  output logic                  par_o
);

  always_comb begin
    par_o = (^data_i) ^ odd_i;
  end

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART TX frame sequencer: start, LSB-first data, optional parity, stop; one phase per baud clock.
// Parity insertion is built only when UART_TX_PARITY_EN is defined; otherwise par_bit is tied to 0.
module uart_tx_frame_ctrl
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            mux_q, mux_d;
  logic                  ser_q, ser_d;
  logic                  busy_q, busy_d;

`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
  logic pen_q, pen_d;
  logic par_calc;

  uart_tx_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity_calc (
    .data_i(P_DATA),
    .odd_i (PAR_TYP),
    .par_o (par_calc)
  );
`else
  logic unused_par_cfg;
  assign unused_par_cfg = PAR_EN ^ PAR_TYP;
`endif

  // Outputs are decoded from the next state so every output comes straight from a flop.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    mux_d   = mux_q;
    ser_d   = ser_q;
    busy_d  = busy_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
    pen_d   = pen_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (DATA_VALID) begin
          state_d = ST_START;
          shift_d = P_DATA;
          cnt_d   = '0;
          busy_d  = 1'b1;
          mux_d   = MUX_START;
`ifdef UART_TX_PARITY_EN
          par_d   = par_calc;
          pen_d   = PAR_EN;
`endif
        end
      end
      ST_START: begin
        state_d = ST_DATA;
        cnt_d   = '0;
        mux_d   = MUX_SERIAL;
        ser_d   = shift_q[0];
        shift_d = shift_q >> 1;
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_STOP;
          mux_d   = MUX_STOP;
`ifdef UART_TX_PARITY_EN
          if (pen_q) begin
            state_d = ST_PARITY;
            mux_d   = MUX_PARITY;
          end
`endif
        end else begin
          cnt_d   = cnt_q + 1'b1;
          ser_d   = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        state_d = ST_STOP;
        mux_d   = MUX_STOP;
      end
`endif
      ST_STOP: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
        mux_d   = MUX_STOP;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        mux_d   = MUX_STOP;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      mux_q   <= MUX_STOP;
      ser_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
      pen_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      mux_q   <= mux_d;
      ser_q   <= ser_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
      pen_q   <= pen_d;
`endif
    end
  end

  assign mux_sel  = mux_q;
  assign ser_data = ser_q;
  assign busy     = busy_q;
`ifdef UART_TX_PARITY_EN
  assign par_bit  = par_q;
`else
  assign par_bit  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Scoreboard bench for uart_tx_frame_ctrl: expected frame beats are queued at request time
// and compared each busy cycle against the TX line reconstructed through a mux model.
module tb_uart_tx_frame_ctrl;
  import uart_tx_pkg::*;

  localparam int W = 8;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] mux;
    logic       line;
    logic       par;
  } beat_t;

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] P_DATA;
  logic         DATA_VALID;
  logic         PAR_EN;
  logic         PAR_TYP;
  logic [1:0]   mux_sel;
  logic         ser_data;
  logic         par_bit;
  logic         busy;

  beat_t       exp_q[$];
  int unsigned len_q[$];
  int unsigned run_len = 0;
  logic        last_par = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  uart_tx_frame_ctrl #(
    .DATA_WIDTH(W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .mux_sel   (mux_sel),
    .ser_data  (ser_data),
    .par_bit   (par_bit),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned frame_len(input logic pen);
    return W + 2 + ((PAR_BUILD && pen) ? 1 : 0);
  endfunction

  // Drive a request and queue the frame it must produce.
  task automatic send(input logic [W-1:0] d, input logic pen, input logic ptyp);
    beat_t b;
    logic  p;
    p = PAR_BUILD ? ((^d) ^ ptyp) : 1'b0;
    DATA_VALID = 1'b1;
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    b = '{mux: MUX_START, line: 1'b0, par: p};
    exp_q.push_back(b);
    for (int i = 0; i < W; i++) begin
      b = '{mux: MUX_SERIAL, line: d[i], par: p};
      exp_q.push_back(b);
    end
    if (PAR_BUILD && pen) begin
      b = '{mux: MUX_PARITY, line: p, par: p};
      exp_q.push_back(b);
    end
    b = '{mux: MUX_STOP, line: 1'b1, par: p};
    exp_q.push_back(b);
    len_q.push_back(frame_len(pen));
    last_par = p;
  endtask

  task automatic idle_check(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge CLK);
      check("idle_mux", 32'(mux_sel), 32'(MUX_STOP));
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_par", 32'(par_bit), 32'(last_par));
    end
  endtask

  // One request pulse followed by ignored junk on the inputs until the frame ends.
  task automatic frame(input logic [W-1:0] d, input logic pen, input logic ptyp);
    send(d, pen, ptyp);
    @(negedge CLK);
    DATA_VALID = 1'b0;
    P_DATA     = ~d;
    PAR_EN     = ~pen;
    PAR_TYP    = ~ptyp;
    repeat (frame_len(pen) - 1) @(negedge CLK);
    idle_check(2);
  endtask

  always @(negedge CLK) begin
    if (RST) begin
      if (busy) begin
        run_len++;
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          beat_t b;
          logic  line;
          b = exp_q.pop_front();
          case (mux_sel)
            MUX_START:  line = 1'b0;
            MUX_SERIAL: line = ser_data;
            MUX_PARITY: line = par_bit;
            default:    line = 1'b1;
          endcase
          check("mux_sel", 32'(mux_sel), 32'(b.mux));
          check("tx_line", 32'(line), 32'(b.line));
          check("par_bit", 32'(par_bit), 32'(b.par));
        end
      end else if (run_len != 0) begin
        if (len_q.size() == 0) check("len_underflow", 32'(len_q.size()), 32'd1);
        else check("frame_len", run_len, len_q.pop_front());
        run_len = 0;
      end
    end
  end

  initial begin
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    RST        = 1'b0;
    DATA_VALID = 1'b0;
    P_DATA     = '0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;

    @(negedge CLK);
    check("rst_mux", 32'(mux_sel), 32'(MUX_STOP));
    check("rst_ser", 32'(ser_data), 32'd0);
    check("rst_par", 32'(par_bit), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    idle_check(2);

    frame(8'hA5, 1'b1, 1'b0);
    frame(8'h01, 1'b1, 1'b1);
    frame(8'hFF, 1'b0, 1'b0);
    frame(8'h6E, 1'b1, 1'b0);

    // DATA_VALID held high; P_DATA changes mid-frame, second frame after one idle cycle.
    d1 = 8'h3C;
    d2 = 8'hC3;
    send(d1, 1'b1, 1'b1);
    @(negedge CLK);
    P_DATA  = 8'h99;
    PAR_EN  = 1'b0;
    PAR_TYP = 1'b0;
    repeat (frame_len(1'b1) - 1) @(negedge CLK);
    @(negedge CLK);
    check("gap_busy", 32'(busy), 32'd0);
    check("gap_mux", 32'(mux_sel), 32'(MUX_STOP));
    send(d2, 1'b1, 1'b1);
    @(negedge CLK);
    DATA_VALID = 1'b0;
    P_DATA     = 8'h00;
    repeat (frame_len(1'b1) - 1) @(negedge CLK);
    idle_check(2);

    // Reset during DATA bit 3: partial frame discarded, line stays high afterwards.
    send(8'h5A, 1'b0, 1'b0);
    @(negedge CLK);
    DATA_VALID = 1'b0;
    repeat (4) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    check("arst_mux", 32'(mux_sel), 32'(MUX_STOP));
    check("arst_ser", 32'(ser_data), 32'd0);
    check("arst_par", 32'(par_bit), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    len_q.delete();
    run_len  = 0;
    last_par = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    idle_check(5);

    frame(8'h81, 1'b1, 1'b1);

    check("sb_beats_left", 32'(exp_q.size()), 32'd0);
    check("sb_lens_left", 32'(len_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
